// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Optional signed-overflow flag output when ALU_OVF_EN is defined.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alucontrol,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
`ifdef ALU_OVF_EN
   output logic             overflow,
`endif
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, MUL} state_e;

   state_e           state_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             lt;
   logic [WIDTH-1:0] alu_d;
   logic [WIDTH-1:0] acc_d;
   logic             accept;
   logic             is_mul;
   logic             mul_done;

`ifdef ALU_OVF_EN
   logic ovf_q;
   logic ovf_d;
`endif

   assign in_ready = reset_n && (state_q == IDLE)
                     && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (alucontrol == 3'b011);
   assign mul_done = (cnt_q == CW'(WIDTH));

   assign sum  = srca + srcb;
   assign diff = srca - srcb;
   assign lt   = $signed(srca) < $signed(srcb);

   assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

   always_comb begin
      alu_d = '0;
      case (alucontrol)
         3'b000:  alu_d = srca & srcb;
         3'b001:  alu_d = srca | srcb;
         3'b010:  alu_d = sum;
         3'b110:  alu_d = diff;
         3'b111:  alu_d = {{(WIDTH-1){1'b0}}, lt};
         default: alu_d = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   always_comb begin
      ovf_d = 1'b0;
      if (alucontrol == 3'b010)
         ovf_d = (srca[WIDTH-1] == srcb[WIDTH-1])
                 && (sum[WIDTH-1] != srca[WIDTH-1]);
      else if (alucontrol == 3'b110)
         ovf_d = (srca[WIDTH-1] != srcb[WIDTH-1])
                 && (diff[WIDTH-1] != srca[WIDTH-1]);
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
`ifdef ALU_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && !is_mul) begin
                  result_q    <= alu_d;
                  zero_q      <= (alu_d == '0);
                  out_valid_q <= 1'b1;
`ifdef ALU_OVF_EN
                  ovf_q       <= ovf_d;
`endif
               end else if (accept) begin
                  mcand_q     <= srca;
                  mplier_q    <= srcb;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b0;
                  state_q     <= MUL;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            MUL: begin
               // WIDTH iterations, then one extra edge to publish acc
               if (mul_done) begin
                  result_q    <= acc_q;
                  zero_q      <= (acc_q == '0);
                  out_valid_q <= 1'b1;
`ifdef ALU_OVF_EN
                  ovf_q       <= 1'b0;
`endif
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end else begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + 1'b1;
                  if (out_ready)
                     out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
`ifdef ALU_OVF_EN
   assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alucontrol;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
`ifdef ALU_OVF_EN
   logic        overflow;
`endif

   int total;
   int passed;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .alucontrol(alucontrol),
      .srca(srca),
      .srcb(srcb),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
`ifdef ALU_OVF_EN
      .overflow(overflow),
`endif
      .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      alucontrol = op;
      srca       = a;
      srcb       = b;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
   endtask

   initial begin
      int bad;
      int seen;
      total      = 0;
      passed     = 0;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      alucontrol = 3'b000;
      srca       = '0;
      srcb       = '0;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      out_ready = 1'b1;
      issue(3'b010, 32'h7FFF_FFFF, 32'h1);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_result", result, 32'h8000_0000);
      chk("add_zero", 32'(zero), 32'd0);
`ifdef ALU_OVF_EN
      chk("add_ovf", 32'(overflow), 32'd1);
`endif

      issue(3'b110, 32'd5, 32'd5);
      chk("sub_result", result, 32'd0);
      chk("sub_zero", 32'(zero), 32'd1);
`ifdef ALU_OVF_EN
      chk("sub_ovf", 32'(overflow), 32'd0);
`endif
      issue(3'b111, 32'hFFFF_FFFF, 32'd1);
      chk("slt_neg", result, 32'd1);
      issue(3'b111, 32'd1, 32'hFFFF_FFFF);
      chk("slt_pos", result, 32'd0);
      chk("slt_pos_zero", 32'(zero), 32'd1);
      issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
      chk("or_result", result, 32'h0000_00FF);
      issue(3'b101, 32'h1234_5678, 32'h1);
      chk("undef_result", result, 32'd0);
      chk("undef_zero", 32'(zero), 32'd1);

      // mul: result must appear exactly 33 edges after the accept edge
      issue(3'b011, 32'hFFFF_FFFF, 32'd3);
      bad = 0;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      chk("mul_busy", 32'(bad), 32'd0);
      tick();
      chk("mul_valid", 32'(out_valid), 32'd1);
      chk("mul_result", result, 32'hFFFF_FFFD);
      tick();
      chk("mul_drain", 32'(out_valid), 32'd0);

      out_ready = 1'b0;
      issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0
             || result !== 32'h0000_F000) bad++;
         tick();
      end
      chk("bp_hold", 32'(bad), 32'd0);
      chk("bp_result", result, 32'h0000_F000);
      out_ready  = 1'b1;
      alucontrol = 3'b010;
      srca       = 32'd2;
      srcb       = 32'd3;
      in_valid   = 1'b1;
      #1;
      chk("bp_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", result, 32'd5);
      tick();
      chk("b2b_drain", 32'(out_valid), 32'd0);

      issue(3'b011, 32'd7, 32'd6);
      for (int i = 0; i < 10; i++) tick();
      reset_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_ready", 32'(in_ready), 32'd0);
      tick();
      reset_n = 1'b1;
      #1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid === 1'b1) seen++;
         tick();
      end
      chk("mrst_no_out", 32'(seen), 32'd0);

      issue(3'b011, 32'd7, 32'd6);
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         if (out_valid === 1'b1) seen = 1;
         else tick();
      end
      chk("mul2_done", 32'(seen), 32'd1);
      chk("mul2_result", result, 32'd42);
      tick();
      issue(3'b010, 32'd10, 32'd20);
      chk("post_add", result, 32'd30);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
